// File: rtl/ysyx_24100029_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_24100029_lsu
//  Purpose  : Memory-access stage. Issues a single outstanding data-memory
//             request per load/store, formats byte lanes and extends loads.
//  Revision : 1.0  initial release
// ============================================================================
module ysyx_24100029_lsu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    // execute-stage handshake
    input  logic              valid_last,
    output logic              ready_last,
    input  logic [DATA_W-1:0] EX_result,
    input  logic [DATA_W-1:0] rs2_value,
    input  logic [2:0]        funct3,
    input  logic              mem_wen,
    input  logic              mem_ren,
    input  logic [4:0]        rd,
    input  logic              R_wen,
    input  logic [3:0]        csr_wen,
    input  logic [DATA_W-1:0] rd_value,
    // write-back handshake
    output logic              valid_next,
    input  logic              ready_next,
    output logic [DATA_W-1:0] wb_data,
    output logic [4:0]        rd_next,
    output logic              R_wen_next,
    output logic [3:0]        csr_wen_next,
    output logic [DATA_W-1:0] rd_value_next,
    output logic              misalign_err,
    // data-memory bus
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic [ADDR_W-1:0] dmem_req_addr,
    output logic              dmem_req_wen,
    output logic [DATA_W-1:0] dmem_req_wdata,
    output logic [3:0]        dmem_req_wstrb,
    input  logic              dmem_resp_valid,
    input  logic [DATA_W-1:0] dmem_resp_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] ex_q, ex_d;
    logic [DATA_W-1:0] rs2_q, rs2_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              store_q, store_d;
    logic              load_q, load_d;
    logic [4:0]        rd_q, rd_d;
    logic              rwen_q, rwen_d;
    logic [3:0]        csr_q, csr_d;
    logic [DATA_W-1:0] rdval_q, rdval_d;
    logic [DATA_W-1:0] wb_q, wb_d;
    logic              mis_q, mis_d;

    logic              w_mis_in;
    logic              w_mem_in;
    logic [DATA_W-1:0] w_shift;
    logic [DATA_W-1:0] w_load_fmt;

    assign w_mem_in = mem_wen | mem_ren;
    assign w_mis_in = ((funct3[1:0] == 2'b01) && EX_result[0])
                    | ((funct3[1:0] == 2'b10) && (EX_result[1:0] != 2'b00));

    // Bring the addressed byte/halfword down to lane 0 before extension.
    assign w_shift = dmem_resp_rdata >> {ex_q[1:0], 3'b000};

    always_comb begin
        w_load_fmt = w_shift;
        case (funct3_q)
            3'b000:  w_load_fmt = {{(DATA_W-8){w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_load_fmt = {{(DATA_W-16){w_shift[15]}}, w_shift[15:0]};
            3'b100:  w_load_fmt = {{(DATA_W-8){1'b0}}, w_shift[7:0]};
            3'b101:  w_load_fmt = {{(DATA_W-16){1'b0}}, w_shift[15:0]};
            default: w_load_fmt = w_shift;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        ex_d     = ex_q;
        rs2_d    = rs2_q;
        funct3_d = funct3_q;
        store_d  = store_q;
        load_d   = load_q;
        rd_d     = rd_q;
        rwen_d   = rwen_q;
        csr_d    = csr_q;
        rdval_d  = rdval_q;
        wb_d     = wb_q;
        mis_d    = mis_q;
        case (state_q)
            ST_IDLE: begin
                if (valid_last) begin
                    ex_d     = EX_result;
                    rs2_d    = rs2_value;
                    funct3_d = funct3;
                    // A store wins when both enables are set.
                    store_d  = mem_wen;
                    load_d   = mem_ren & ~mem_wen;
                    rd_d     = rd;
                    rwen_d   = R_wen & ~mem_wen;
                    csr_d    = csr_wen;
                    rdval_d  = rd_value;
                    wb_d     = EX_result;
                    mis_d    = w_mem_in & w_mis_in;
                    state_d  = (w_mem_in && !w_mis_in) ? ST_REQ : ST_OUT;
                end
            end
            ST_REQ: begin
                if (dmem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dmem_resp_valid) begin
                    state_d = ST_OUT;
                    if (load_q) begin
                        wb_d = w_load_fmt;
                    end
                end
            end
            ST_OUT: begin
                if (ready_next) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            ex_q     <= '0;
            rs2_q    <= '0;
            funct3_q <= '0;
            store_q  <= 1'b0;
            load_q   <= 1'b0;
            rd_q     <= '0;
            rwen_q   <= 1'b0;
            csr_q    <= '0;
            rdval_q  <= '0;
            wb_q     <= '0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ex_q     <= ex_d;
            rs2_q    <= rs2_d;
            funct3_q <= funct3_d;
            store_q  <= store_d;
            load_q   <= load_d;
            rd_q     <= rd_d;
            rwen_q   <= rwen_d;
            csr_q    <= csr_d;
            rdval_q  <= rdval_d;
            wb_q     <= wb_d;
            mis_q    <= mis_d;
        end
    end

    // Store lane placement; strobes stay zero for reads.
    always_comb begin
        dmem_req_wstrb = 4'b0000;
        dmem_req_wdata = rs2_q;
        case (funct3_q[1:0])
            2'b00: begin
                dmem_req_wdata = {4{rs2_q[7:0]}};
                if (store_q) dmem_req_wstrb = 4'b0001 << ex_q[1:0];
            end
            2'b01: begin
                dmem_req_wdata = {2{rs2_q[15:0]}};
                if (store_q) dmem_req_wstrb = 4'b0011 << ex_q[1:0];
            end
            default: begin
                dmem_req_wdata = rs2_q;
                if (store_q) dmem_req_wstrb = 4'b1111;
            end
        endcase
    end

    assign ready_last     = (state_q == ST_IDLE);
    assign valid_next     = (state_q == ST_OUT);
    assign dmem_req_valid = (state_q == ST_REQ);
    assign dmem_req_addr  = {ex_q[ADDR_W-1:2], 2'b00};
    assign dmem_req_wen   = store_q;
    assign wb_data        = wb_q;
    assign rd_next        = rd_q;
    assign R_wen_next     = rwen_q;
    assign csr_wen_next   = csr_q;
    assign rd_value_next  = rdval_q;
    assign misalign_err   = mis_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24100029_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_24100029_lsu
//  Purpose  : Self-checking bench for the memory-access stage against a
//             behavioural model of the access rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ysyx_24100029_lsu;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid_last, ready_last;
    logic [31:0] EX_result, rs2_value, rd_value;
    logic [2:0]  funct3;
    logic        mem_wen, mem_ren, R_wen;
    logic [4:0]  rd;
    logic [3:0]  csr_wen;
    logic        valid_next, ready_next;
    logic [31:0] wb_data, rd_value_next;
    logic [4:0]  rd_next;
    logic        R_wen_next, misalign_err;
    logic [3:0]  csr_wen_next;
    logic        dmem_req_valid, dmem_req_ready, dmem_req_wen;
    logic [31:0] dmem_req_addr, dmem_req_wdata;
    logic [3:0]  dmem_req_wstrb;
    logic        dmem_resp_valid;
    logic [31:0] dmem_resp_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    ysyx_24100029_lsu #(.ADDR_W(32), .DATA_W(32)) u_dut (
        .clock(clock), .reset(reset),
        .valid_last(valid_last), .ready_last(ready_last),
        .EX_result(EX_result), .rs2_value(rs2_value), .funct3(funct3),
        .mem_wen(mem_wen), .mem_ren(mem_ren), .rd(rd), .R_wen(R_wen),
        .csr_wen(csr_wen), .rd_value(rd_value),
        .valid_next(valid_next), .ready_next(ready_next), .wb_data(wb_data),
        .rd_next(rd_next), .R_wen_next(R_wen_next), .csr_wen_next(csr_wen_next),
        .rd_value_next(rd_value_next), .misalign_err(misalign_err),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_req_addr(dmem_req_addr), .dmem_req_wen(dmem_req_wen),
        .dmem_req_wdata(dmem_req_wdata), .dmem_req_wstrb(dmem_req_wstrb),
        .dmem_resp_valid(dmem_resp_valid), .dmem_resp_rdata(dmem_resp_rdata)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic scramble_inputs;
        EX_result = $urandom;
        rs2_value = $urandom;
        rd_value  = $urandom;
        funct3    = 3'($urandom);
        mem_wen   = 1'($urandom);
        mem_ren   = 1'($urandom);
        R_wen     = 1'($urandom);
        rd        = 5'($urandom);
        csr_wen   = 4'($urandom);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_value({tag, "_vnext"}, 32'(valid_next), 32'd0);
        check_value({tag, "_rdy"}, 32'(ready_last), 32'd1);
        check_value({tag, "_req"}, 32'(dmem_req_valid), 32'd0);
        check_value({tag, "_mis"}, 32'(misalign_err), 32'd0);
        check_value({tag, "_wb"}, wb_data, 32'd0);
        check_value({tag, "_rd"}, 32'(rd_next), 32'd0);
        check_value({tag, "_rwen"}, 32'(R_wen_next), 32'd0);
        check_value({tag, "_csr"}, 32'(csr_wen_next), 32'd0);
        check_value({tag, "_rdval"}, rd_value_next, 32'd0);
    endtask

    // Reference for one instruction: drives it, plays the bus, and checks results.
    task automatic run_insn(input logic [31:0] ex, input logic [31:0] rs2, input logic [2:0] f3,
                            input logic wen, input logic ren, input logic [4:0] rdi,
                            input logic rw, input logic [3:0] csr, input logic [31:0] rv,
                            input logic [31:0] rdata, input int req_stall,
                            input int resp_delay, input int out_stall);
        int          off;
        int          nbytes;
        logic        is_mem, is_store, mis;
        logic [31:0] sh, exp_wb, exp_strb, exp_wdata, exp_addr, word;
        off      = int'(ex[1:0]);
        nbytes   = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
        is_mem   = wen | ren;
        is_store = wen;
        mis      = is_mem && ((off % nbytes) != 0);
        exp_addr = ex - 32'(off);
        exp_strb = is_store ? ((nbytes == 4) ? 32'hF : (((32'd1 << nbytes) - 1) << off)) : 32'd0;
        exp_wdata = (nbytes == 1) ? 32'(rs2[7:0]) * 32'h01010101 :
                    (nbytes == 2) ? 32'(rs2[15:0]) * 32'h00010001 : rs2;
        sh = rdata / (32'd1 << (8 * off));
        case (f3)
            3'b000:  word = (sh % 256 >= 128) ? (sh % 256) - 32'd256 : sh % 256;
            3'b001:  word = (sh % 65536 >= 32768) ? (sh % 65536) - 32'd65536 : sh % 65536;
            3'b100:  word = sh % 256;
            3'b101:  word = sh % 65536;
            default: word = sh;
        endcase
        exp_wb = (is_mem && !is_store && !mis) ? word : ex;

        check_value("rdy_before", 32'(ready_last), 32'd1);
        EX_result = ex; rs2_value = rs2; funct3 = f3; mem_wen = wen; mem_ren = ren;
        rd = rdi; R_wen = rw; csr_wen = csr; rd_value = rv; valid_last = 1'b1;
        tick;
        valid_last = 1'b0;
        scramble_inputs;
        check_value("rdy_busy", 32'(ready_last), 32'd0);

        if (!is_mem || mis) begin
            check_value("lat1_vnext", 32'(valid_next), 32'd1);
            check_value("lat1_noreq", 32'(dmem_req_valid), 32'd0);
        end else begin
            check_value("req_vnext0", 32'(valid_next), 32'd0);
            for (int i = 0; i <= req_stall; i++) begin
                check_value("req_valid", 32'(dmem_req_valid), 32'd1);
                check_value("req_addr", dmem_req_addr, exp_addr);
                check_value("req_wen", 32'(dmem_req_wen), 32'(is_store));
                check_value("req_wstrb", 32'(dmem_req_wstrb), exp_strb);
                if (is_store) check_value("req_wdata", dmem_req_wdata, exp_wdata);
                if (i < req_stall) begin
                    dmem_req_ready  = 1'b0;
                    dmem_resp_valid = 1'($urandom);
                    dmem_resp_rdata = $urandom;
                    tick;
                    check_value("req_stall_rdy", 32'(ready_last), 32'd0);
                end
            end
            dmem_resp_valid = 1'b0;
            dmem_req_ready  = 1'b1;
            tick;
            dmem_req_ready = 1'b0;
            check_value("wait_noreq", 32'(dmem_req_valid), 32'd0);
            for (int i = 0; i < resp_delay; i++) begin
                tick;
                check_value("wait_vnext0", 32'(valid_next), 32'd0);
            end
            dmem_resp_valid = 1'b1;
            dmem_resp_rdata = rdata;
            tick;
            dmem_resp_valid = 1'b0;
            dmem_resp_rdata = $urandom;
            check_value("resp_vnext", 32'(valid_next), 32'd1);
        end

        check_value("out_wb", wb_data, exp_wb);
        check_value("out_rd", 32'(rd_next), 32'(rdi));
        check_value("out_rwen", 32'(R_wen_next), 32'(rw & ~wen));
        check_value("out_csr", 32'(csr_wen_next), 32'(csr));
        check_value("out_rdval", rd_value_next, rv);
        check_value("out_mis", 32'(misalign_err), 32'(mis));
        for (int i = 0; i < out_stall; i++) begin
            ready_next = 1'b0;
            tick;
            check_value("hold_vnext", 32'(valid_next), 32'd1);
            check_value("hold_wb", wb_data, exp_wb);
            check_value("hold_rdy", 32'(ready_last), 32'd0);
        end
        ready_next = 1'b1;
        tick;
        ready_next = 1'b0;
        check_value("done_vnext", 32'(valid_next), 32'd0);
        check_value("done_rdy", 32'(ready_last), 32'd1);
    endtask

    initial begin
        logic [2:0] f3_tab [5];
        logic [31:0] rnd;
        f3_tab[0] = 3'b000; f3_tab[1] = 3'b001; f3_tab[2] = 3'b010;
        f3_tab[3] = 3'b100; f3_tab[4] = 3'b101;

        reset = 1'b0; valid_last = 1'b0; ready_next = 1'b0;
        dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_resp_rdata = '0;
        scramble_inputs;
        tick;
        tick;
        check_zero_outputs("reset");
        reset = 1'b1;
        tick;

        // ALU pass-through
        run_insn(32'h1234, 32'h0, 3'b000, 1'b0, 1'b0, 5'd5, 1'b1, 4'h0, 32'h0, 32'h0, 0, 0, 0);
        // LB / LBU from the top byte lane
        run_insn(32'h80000003, 32'h0, 3'b000, 1'b0, 1'b1, 5'd7, 1'b1, 4'h0, 32'h0, 32'h80FF0000, 0, 0, 0);
        run_insn(32'h80000003, 32'h0, 3'b100, 1'b0, 1'b1, 5'd7, 1'b1, 4'h0, 32'h0, 32'h80FF0000, 0, 0, 0);
        // SH to the upper half
        run_insn(32'h10000002, 32'hABCD1234, 3'b001, 1'b1, 1'b0, 5'd9, 1'b1, 4'h0, 32'h0, 32'h0, 0, 1, 0);
        // Bus and write-back backpressure
        run_insn(32'h00000040, 32'h0, 3'b010, 1'b0, 1'b1, 5'd3, 1'b1, 4'h2, 32'h55, 32'hCAFEF00D, 4, 0, 3);
        // Misaligned LW: no request, immediate result
        run_insn(32'h00000002, 32'h0, 3'b010, 1'b0, 1'b1, 5'd4, 1'b1, 4'h0, 32'h0, 32'h0, 0, 0, 0);

        // Stray response in IDLE
        dmem_resp_valid = 1'b1; dmem_resp_rdata = 32'hDEADBEEF;
        tick;
        dmem_resp_valid = 1'b0;
        check_value("stray_vnext", 32'(valid_next), 32'd0);
        check_value("stray_rdy", 32'(ready_last), 32'd1);
        check_value("stray_req", 32'(dmem_req_valid), 32'd0);

        // Reset while waiting for a response
        EX_result = 32'h40; funct3 = 3'b010; mem_ren = 1'b1; mem_wen = 1'b0;
        R_wen = 1'b1; rd = 5'd3; csr_wen = 4'h1; rd_value = 32'h77;
        valid_last = 1'b1; dmem_req_ready = 1'b1;
        tick;
        valid_last = 1'b0;
        tick;
        dmem_req_ready = 1'b0;
        check_value("rst_wait_noreq", 32'(dmem_req_valid), 32'd0);
        reset = 1'b0;
        tick;
        check_zero_outputs("rst_mid");
        reset = 1'b1; dmem_resp_valid = 1'b1; dmem_resp_rdata = 32'h12345678;
        tick;
        dmem_resp_valid = 1'b0;
        check_zero_outputs("rst_late_resp");
        run_insn(32'h00000021, 32'h0, 3'b000, 1'b0, 1'b1, 5'd8, 1'b1, 4'h0, 32'h0, 32'h00003300, 0, 0, 0);

        // Randomised mix
        for (int n = 0; n < 300; n++) begin
            int kind;
            kind = int'($urandom_range(0, 3));
            rnd  = $urandom;
            run_insn($urandom, $urandom, f3_tab[$urandom_range(0, 4)],
                     1'(kind == 2 || kind == 3), 1'(kind == 1 || kind == 3),
                     5'(rnd), rnd[5], rnd[9:6], $urandom, $urandom,
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                     int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
